// File: rtl/fifo_wr_scheduler.sv
// Write-side round-robin arbiter, occupancy tracker, read issue and flush
// sequencer in front of a single status-less FIFO.
module fifo_wr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_rd_en_o,
  input  logic                          rd_req_i,
  output logic                          rd_valid_o,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(NUM_REQ - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   grant_idx;
  logic            grant_vld;
  logic            run_rd, flush_rd, flush_finish;

  // Grant search starts at rr_q and wraps; suppressed while in reset so no
  // output asserts before the first clean cycle.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    req_ready_o = '0;
    fifo_data_o = '0;
    if (!rst_i && state_q == RUN && count_q < DEPTH_C) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_vld && req_valid_i[(int'(rr_q) + k) % NUM_REQ]) begin
          grant_vld = 1'b1;
          grant_idx = PW'((int'(rr_q) + k) % NUM_REQ);
        end
      end
    end
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
      fifo_data_o            = req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en_o = grant_vld;
  assign run_rd       = !rst_i && state_q == RUN   && rd_req_i && count_q != '0;
  assign flush_rd     = !rst_i && state_q == FLUSH && count_q != '0;
  assign fifo_rd_en_o = run_rd | flush_rd;
  // Flush ends on the edge where the last entry leaves (or immediately if empty).
  assign flush_finish = state_q == FLUSH && count_q <= CW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i) state_d = FLUSH;
      FLUSH:   if (flush_finish) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      count_q      <= '0;
      rr_q         <= '0;
      rd_valid_o   <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_q + CW'(fifo_wr_en_o) - CW'(fifo_rd_en_o);
      rd_valid_o   <= run_rd;
      flush_done_o <= flush_finish;
      if (grant_vld) rr_q <= (grant_idx == LAST_C) ? '0 : grant_idx + PW'(1);
    end
  end

  assign count_o = count_q;
  assign full_o  = count_q == DEPTH_C;
  assign empty_o = count_q == '0;

endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Bench for fifo_wr_scheduler: behavioural FIFO attached to the DUT, a
// read-data scoreboard, a table of arbitration vectors and corner sequences.
module tb_fifo_wr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int DW      = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*DW-1:0]    req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     fifo_wr_en_o;
  logic [DW-1:0]            fifo_data_o;
  logic                     fifo_rd_en_o;
  logic                     rd_req_i;
  logic                     rd_valid_o;
  logic                     flush_i;
  logic                     flush_done_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic                     full_o;
  logic                     empty_o;

  fifo_wr_scheduler #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o), .fifo_rd_en_o(fifo_rd_en_o),
    .rd_req_i(rd_req_i), .rd_valid_o(rd_valid_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Attached FIFO: registered data_o, no status outputs.
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk_i) begin
    if (rst_i) mdl_q.delete();
    else begin
      if (fifo_wr_en_o && mdl_q.size() >= DEPTH) begin
        n_errors++;
        $display("FAIL fifo_overflow: wr_en with %0d entries", mdl_q.size());
      end
      if (fifo_rd_en_o) begin
        if (mdl_q.size() == 0) begin
          n_errors++;
          $display("FAIL fifo_underflow: rd_en with 0 entries");
        end else fifo_dout <= mdl_q.pop_front();
      end
      if (fifo_wr_en_o && mdl_q.size() < DEPTH) mdl_q.push_back(fifo_data_o);
    end
  end

  // Scoreboard: every valid read word must be the oldest expected write.
  always @(negedge clk_i) begin
    if (!rst_i && rd_valid_o) begin
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_valid_unexpected: data %0h with empty scoreboard", fifo_dout);
      end else check("rd_data", fifo_dout, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    req_data_i[idx*DW +: DW] = d;
  endtask

  // Single write from requester 0 (only valid requester, so always granted).
  task automatic wr_one(input logic [DW-1:0] d);
    req_valid_i = 4'b0001;
    set_data(0, d);
    #1;
    check("wr_ready", req_ready_o, 4'b0001);
    exp_q.push_back(d);
    tick();
    req_valid_i = '0;
  endtask

  task automatic drain(input int n);
    req_valid_i = '0;
    rd_req_i = 1'b1;
    repeat (n) begin
      #1;
      check("drain_rd_en", fifo_rd_en_o, 1'b1);
      tick();
    end
    rd_req_i = 1'b0;
    tick();
    check("drain_count", count_o, 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_ready;
    logic [DW-1:0]      exp_data;
  } arb_vec_t;

  arb_vec_t arb_tbl[7];

  initial begin
    arb_tbl[0] = '{4'b0000, 4'b0000, 4'd0};
    arb_tbl[1] = '{4'b1011, 4'b0001, 4'd1};
    arb_tbl[2] = '{4'b1011, 4'b0010, 4'd2};
    arb_tbl[3] = '{4'b1011, 4'b1000, 4'd4};
    arb_tbl[4] = '{4'b1011, 4'b0001, 4'd1};
    arb_tbl[5] = '{4'b1011, 4'b0010, 4'd2};
    arb_tbl[6] = '{4'b1011, 4'b1000, 4'd4};

    rst_i = 1'b1; req_valid_i = 4'hF; rd_req_i = 1'b0; flush_i = 1'b0;
    req_data_i = {4'd4, 4'd3, 4'd2, 4'd1};

    // Reset held two cycles with all requesters valid.
    repeat (2) begin
      tick();
      check("rst_ready", req_ready_o, 4'b0000);
      check("rst_wr_en", fifo_wr_en_o, 1'b0);
      check("rst_count", count_o, 0);
      check("rst_empty", empty_o, 1'b1);
      check("rst_full", full_o, 1'b0);
      check("rst_rd_valid", rd_valid_o, 1'b0);
      check("rst_flush_done", flush_done_o, 1'b0);
    end
    rst_i = 1'b0;
    req_valid_i = '0;

    // Round robin from the vector table.
    for (int i = 0; i < 7; i++) begin
      req_valid_i = arb_tbl[i].valid;
      #1;
      check($sformatf("rr_ready[%0d]", i), req_ready_o, arb_tbl[i].exp_ready);
      check($sformatf("rr_wr_en[%0d]", i), fifo_wr_en_o, arb_tbl[i].exp_ready != '0);
      check($sformatf("rr_data[%0d]", i), fifo_data_o, arb_tbl[i].exp_data);
      if (arb_tbl[i].exp_ready != '0) exp_q.push_back(arb_tbl[i].exp_data);
      tick();
    end
    req_valid_i = '0;
    check("rr_count", count_o, 6);
    drain(6);

    // Fill to full, then a read at full still blocks the write.
    for (int k = 0; k < DEPTH; k++) wr_one(DW'(k));
    check("full_count", count_o, DEPTH);
    check("full_flag", full_o, 1'b1);
    check("full_empty", empty_o, 1'b0);
    req_valid_i = 4'b0001; set_data(0, 4'd8);
    #1;
    check("full_ready_blocked", req_ready_o, 4'b0000);
    rd_req_i = 1'b1;
    #1;
    check("full_rd_en", fifo_rd_en_o, 1'b1);
    check("full_rd_ready_blocked", req_ready_o, 4'b0000);
    check("full_rd_wr_en", fifo_wr_en_o, 1'b0);
    tick();
    rd_req_i = 1'b0;
    check("full_after_rd", count_o, DEPTH - 1);
    wr_one(4'd8);
    check("full_refill", count_o, DEPTH);
    drain(DEPTH);

    // Read latency and read-while-empty.
    wr_one(4'd5);
    wr_one(4'd6);
    rd_req_i = 1'b1;
    #1; check("lat_rd_en0", fifo_rd_en_o, 1'b1);
    check("lat_rd_valid_pre", rd_valid_o, 1'b0);
    tick();
    check("lat_rd_valid0", rd_valid_o, 1'b1);
    check("lat_rd_en1", fifo_rd_en_o, 1'b1);
    tick();
    check("lat_rd_valid1", rd_valid_o, 1'b1);
    check("lat_empty_rd_en", fifo_rd_en_o, 1'b0);
    tick();
    rd_req_i = 1'b0;
    check("lat_empty_rd_valid", rd_valid_o, 1'b0);
    check("lat_count", count_o, 0);

    // Simultaneous read and write at count 3.
    wr_one(4'd7); wr_one(4'd8); wr_one(4'd9);
    for (int k = 0; k < 2; k++) begin
      req_valid_i = 4'b0001; set_data(0, DW'(10 + k)); rd_req_i = 1'b1;
      #1;
      check("rw_ready", req_ready_o, 4'b0001);
      check("rw_rd_en", fifo_rd_en_o, 1'b1);
      exp_q.push_back(DW'(10 + k));
      tick();
      check("rw_count", count_o, 3);
    end
    rd_req_i = 1'b0;
    drain(3);

    // Flush at count 5 with all requesters valid.
    for (int k = 1; k <= 5; k++) wr_one(DW'(k));
    check("fl_count", count_o, 5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
    req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("fl_ready[%0d]", k), req_ready_o, 4'b0000);
      check($sformatf("fl_rd_en[%0d]", k), fifo_rd_en_o, 1'b1);
      check($sformatf("fl_done_early[%0d]", k), flush_done_o, 1'b0);
      check($sformatf("fl_rd_valid[%0d]", k), rd_valid_o, 1'b0);
      if (k == 2) flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    check("fl_done", flush_done_o, 1'b1);
    check("fl_done_count", count_o, 0);
    check("fl_run_ready", req_ready_o, 4'b0010);
    req_valid_i = '0;
    tick();
    check("fl_done_pulse_end", flush_done_o, 1'b0);

    // Flush while empty: one FLUSH cycle, then the done pulse.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    req_valid_i = 4'b0001;
    #1;
    check("fe_ready", req_ready_o, 4'b0000);
    check("fe_rd_en", fifo_rd_en_o, 1'b0);
    check("fe_done_early", flush_done_o, 1'b0);
    tick();
    check("fe_done", flush_done_o, 1'b1);
    check("fe_run_ready", req_ready_o, 4'b0001);
    req_valid_i = '0;
    tick();
    check("fe_done_end", flush_done_o, 1'b0);

    // Reset during flush cycle 2 aborts without a done pulse.
    wr_one(4'd1); wr_one(4'd2); wr_one(4'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
    #1; check("fr_rd_en", fifo_rd_en_o, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("fr_count", count_o, 0);
    check("fr_done", flush_done_o, 1'b0);
    req_valid_i = 4'b0001;
    #1;
    check("fr_run_ready", req_ready_o, 4'b0001);
    req_valid_i = '0;
    repeat (3) begin
      tick();
      check("fr_no_done", flush_done_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
